// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - shared state encoding and event codes for the tap classifier
package tap_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  localparam int TAP_SINGLE = 1;
  localparam int TAP_DOUBLE = 2;
  localparam int TAP_TRIPLE = 3;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - small synchronous event queue; a push while full is
// accepted only when a pop frees the head slot in the same cycle.
module event_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // When full, wr_ptr equals rd_ptr, so a push-with-pop overwrites the slot being consumed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tap_classifier.sv
// rtl/tap_classifier.sv - groups debounced press pulses into single/double/triple
// tap events and queues them behind a valid/ready handshake.
module tap_classifier
  import tap_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50_000_000,
  parameter int MAX_TAPS      = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            pulse_i,
  output logic                            evt_valid_o,
  output logic [$clog2(MAX_TAPS+1)-1:0]   evt_code_o,
  input  logic                            evt_ready_i,
  output logic                            busy_o,
  output logic                            dropped_o
);

  localparam int CW = $clog2(MAX_TAPS + 1);
  localparam int TW = $clog2(WINDOW_CYCLES);

  state_t        state;
  logic [CW-1:0] tap_cnt;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          push;
  logic [CW-1:0] push_code;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign timeout     = (timer == TW'(WINDOW_CYCLES - 1));
  assign evt_valid_o = !fifo_empty;
  assign pop         = evt_valid_o && evt_ready_i;

  // A pulse always outranks a same-cycle timeout, extending the burst.
  always_comb begin
    push      = 1'b0;
    push_code = '0;
    if (state == COUNTING) begin
      if (pulse_i) begin
        if (tap_cnt == CW'(MAX_TAPS - 1)) begin
          push      = 1'b1;
          push_code = CW'(MAX_TAPS);
        end
      end else if (timeout) begin
        push      = 1'b1;
        push_code = tap_cnt;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      timer     <= '0;
      busy_o    <= 1'b0;
      dropped_o <= 1'b0;
    end else begin
      dropped_o <= push && fifo_full && !pop;
      case (state)
        IDLE: begin
          if (pulse_i) begin
            tap_cnt <= CW'(TAP_SINGLE);
            timer   <= '0;
            state   <= COUNTING;
            busy_o  <= 1'b1;
          end
        end
        COUNTING: begin
          if (pulse_i) begin
            timer <= '0;
            if (tap_cnt == CW'(MAX_TAPS - 1)) begin
              tap_cnt <= '0;
              state   <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
            end
          end else if (timeout) begin
            tap_cnt <= '0;
            timer   <= '0;
            state   <= IDLE;
            busy_o  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  event_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .din   (push_code),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (evt_code_o)
  );

endmodule
